// File: rtl/serial_adder_4b.sv
// rtl/serial_adder_4b.sv - bit-serial handshaked adder, LSB first, one result per WIDTH+2 cycles
module serial_adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cy;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_carry;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sr_next;

    assign w_s       = r_sa[0] ^ r_sb[0] ^ r_cy;
    assign w_carry   = (r_sa[0] & r_sb[0]) | (r_cy & (r_sa[0] ^ r_sb[0]));
    assign w_last    = (r_cnt == LAST);
    assign w_sr_next = {w_s, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                w_accept = in_valid & rst_n;
                if (w_accept) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sr   <= '0;
            r_sum  <= '0;
            r_cy   <= 1'b0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_cy  <= c_in;
                        r_cnt <= '0;
                        r_sr  <= '0;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cy  <= w_carry;
                    r_cnt <= r_cnt + 1'b1;
                    // Output registers load on the final bit so they persist past the handshake.
                    if (w_last) begin
                        r_sum  <= w_sr_next;
                        r_cout <= w_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_serial_adder_4b.sv
// tb/tb_serial_adder_4b.sv - scoreboard bench for serial_adder_4b
module tb_serial_adder_4b;

    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         c_in      = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         c_out;
    logic         busy;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W:0] exp_q[$];
    logic [W:0] obs_q[$];
    int         acc_q[$];

    serial_adder_4b #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record handshakes that will complete on the coming rising edge.
    always @(negedge clk) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (rst_n && out_valid && out_ready) obs_q.push_back({c_out, sum});
    end

    function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 4'd5; b = 4'd5; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 4'd0) begin n_err++; $display("FAIL rst_sum: got %h want 0", sum); end
        n_cmp++; if (c_out !== 1'b0) begin n_err++; $display("FAIL rst_c_out: got %b want 0", c_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (acc_q.size() != 0) begin n_err++; $display("FAIL rst_accept: got %0d accepts want 0", acc_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rel_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int busy_n;
        int first_ov;
        logic [W:0] got, want;
        busy_n = 0; first_ov = -1;
        a = 4'd3; b = 4'd4; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        exp_q.push_back(golden(a, b, c_in));
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Cycle i is the one following edge E(i-1); E0 is the acceptance edge.
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (out_valid && first_ov < 0) first_ov = i;
        end
        n_cmp++; if (first_ov - 1 != W) begin n_err++; $display("FAIL basic_latency: out_valid after edge %0d want %0d", first_ov - 1, W); end
        n_cmp++; if (busy_n != W + 1) begin n_err++; $display("FAIL basic_busy: busy %0d cycles want %0d", busy_n, W + 1); end
        @(posedge clk); #1;
        n_cmp++; if (sum !== 4'd7 || c_out !== 1'b0) begin n_err++; $display("FAIL basic_hold: got %b/%h want 0/7", c_out, sum); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL basic_result: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        logic [W-1:0] ta[2];
        logic [W-1:0] tb[2];
        logic         tc[2];
        logic [W:0]   tr[2];
        logic [W:0]   got, want;
        ta[0] = 4'd15; tb[0] = 4'd15; tc[0] = 1'b1; tr[0] = 5'h1F;
        ta[1] = 4'd15; tb[1] = 4'd0;  tc[1] = 1'b1; tr[1] = 5'h10;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a = ta[k]; b = tb[k]; c_in = tc[k]; in_valid = 1'b1;
            exp_q.push_back(golden(a, b, c_in));
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int i = 0; i < 20 && obs_q.size() == k; i++) @(posedge clk);
            #1;
            n_cmp++; if (obs_q.size() != k + 1) begin n_err++; $display("FAIL wrap_timeout: got %0d results want %0d", obs_q.size(), k + 1); end
            n_cmp++; if ({c_out, sum} !== tr[k]) begin n_err++; $display("FAIL wrap_value%0d: got %h want %h", k, {c_out, sum}, tr[k]); end
        end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL wrap_result: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic       got_ov;
        logic [W:0] got, want;
        acc_q.delete();
        got_ov = 1'b0;
        out_ready = 1'b0; a = 4'd1; b = 4'd1; c_in = 1'b0; in_valid = 1'b1;
        exp_q.push_back(golden(a, b, c_in));
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin got_ov = 1'b1; break; end
        end
        n_cmp++; if (got_ov !== 1'b1) begin n_err++; $display("FAIL bp_timeout: out_valid %b want 1", got_ov); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0 cycle %0d", in_ready, i); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1 cycle %0d", out_valid, i); end
            n_cmp++; if (sum !== 4'd2 || c_out !== 1'b0) begin n_err++; $display("FAIL bp_hold: got %b/%h want 0/2 cycle %0d", c_out, sum, i); end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (acc_q.size() != 1) begin n_err++; $display("FAIL bp_accepts: got %0d want 1", acc_q.size()); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL bp_result: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        a = 4'd9; b = 4'd6; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 4'd0) begin n_err++; $display("FAIL mid_sum: got %h want 0", sum); end
        n_cmp++; if (c_out !== 1'b0) begin n_err++; $display("FAIL mid_c_out: got %b want 0", c_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        repeat (12) @(posedge clk); #1;
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL mid_ghost: got %0d results want 0", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_exhaustive();
        logic [W:0] got, want;
        acc_q.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 512; n++) begin
            c_in = n[8]; a = n[7:4]; b = n[3:0]; in_valid = 1'b1;
            exp_q.push_back(golden(a, b, c_in));
            @(posedge clk); #1;
            repeat (5) begin @(posedge clk); #1; end
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (acc_q.size() != 512) begin n_err++; $display("FAIL exh_accepts: got %0d want 512", acc_q.size()); end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_cmp++; if (acc_q[i] - acc_q[i-1] != W + 2) begin n_err++; $display("FAIL exh_spacing: got %0d want %0d at %0d", acc_q[i] - acc_q[i-1], W + 2, i); end
        end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL exh_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL exh_result: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_protocol();
        logic [W:0] got, want;
        acc_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            a = W'(k); b = W'(k * 5 + 3); c_in = k[1];
            if (k % (W + 2) == 0) exp_q.push_back(golden(a, b, c_in));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (acc_q.size() != 4) begin n_err++; $display("FAIL proto_accepts: got %0d want 4", acc_q.size()); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL proto_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_err++; $display("FAIL proto_result: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_4b.md
# serial_adder_4b

Bit-serial, handshaked adder that answers the operand stream produced by the team's adder stimulus/checker logic. It accepts one operand set (a, b, c_in) per valid/ready transaction and computes the sum one bit per clock, LSB first. It returns sum and c_out through a second valid/ready transaction. It is the sequential responder counterpart to the combinational four-bit full adder and is checked against the same golden model (a + b + c_in).

## Interface
Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand set on a/b/c_in is valid.
- in_ready  output  1  block can accept an operand set.
- a  input  WIDTH  operand A; sampled only on the input handshake.
- b  input  WIDTH  operand B; sampled only on the input handshake.
- c_in  input  1  carry in; sampled only on the input handshake.
- out_valid  output  1  sum/c_out hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  bit WIDTH of a + b + c_in.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Internal state:
  - shift registers sa and sb (WIDTH bits).
  - carry register cy.
  - result register sr (WIDTH bits).
  - bit counter cnt (clog2(WIDTH+1) bits).
  - FSM with states IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge:
    - sa <= a, sb <= b, cy <= c_in.
    - cnt <= 0, sr <= 0.
    - go to SHIFT.
- SHIFT:
  - Each edge, full-add sa[0], sb[0], cy:
    - sr <= {s, sr[WIDTH-1:1]}.
    - sa, sb shift right by 1.
    - cy <= carry.
    - cnt <= cnt + 1.
  - The edge where cnt == WIDTH-1 is the final bit; go to DONE.
- DONE:
  - out_valid = 1.
  - sum = sr, c_out = cy, both held stable.
  - On out_valid & out_ready at a rising edge, go to IDLE.
- in_ready is 0 in SHIFT and DONE. in_valid and a/b/c_in are ignored there; no operand is queued.
- out_ready is ignored outside DONE.
- sum and c_out are registered. They keep the last result after the output handshake until the next DONE overwrites them.
- Arithmetic is unsigned. {c_out, sum} == a + b + c_in for every input combination, including wrap-around (e.g. all-ones + 0 + 1 gives sum 0, c_out 1).
- Reset (rst_n low at a rising edge), from any state including mid-SHIFT and DONE:
  - state becomes IDLE.
  - sa, sb, sr, cy, cnt, sum, c_out all become 0.
  - any in-flight result is discarded and never presented.
- Reset values of outputs:
  - in_ready = 0 while rst_n is low, 1 from the first cycle after release.
  - out_valid = 0, sum = 0, c_out = 0, busy = 0.

## Timing
- Input handshake at edge E0.
- SHIFT occupies edges E1..E_WIDTH.
- out_valid rises in the cycle after E_WIDTH, i.e. WIDTH cycles after acceptance (4 for default).
- With out_ready held high:
  - output handshake at E_(WIDTH+1).
  - in_ready is high again in the following cycle.
  - next acceptance at E_(WIDTH+2) at the earliest.
  - sustained throughput is one result per WIDTH+2 cycles (6 for default).
- With out_ready low, DONE holds indefinitely: out_valid, sum and c_out do not change, and in_ready stays 0.
- in_valid high and rst_n low on the same edge: reset wins and the operand is not accepted.
- busy = (state != IDLE). It is registered via the state and goes high the cycle after acceptance.

## Test plan
- Reset released, then a=3, b=4, c_in=0 with in_valid for one cycle:
  - sum=7, c_out=0.
  - out_valid exactly 4 cycles after the acceptance edge.
  - busy high for 5 cycles with out_ready=1.
- a=15, b=15, c_in=1 → sum=15, c_out=1. a=15, b=0, c_in=1 → sum=0, c_out=1 (wrap-around).
- Backpressure: out_ready low for 10 cycles after out_valid rises while in_valid toggles with a=1, b=1:
  - sum/c_out stay stable and in_ready stays 0.
  - no operand is accepted.
  - raising out_ready gives exactly one output handshake, then in_ready=1.
- Reset mid-SHIFT (rst_n low 1 cycle, 2 edges after acceptance of a=9, b=6):
  - next cycle out_valid=0, sum=0, c_out=0, busy=0.
  - in_ready=1 after release.
  - no result ever appears for that operand.
- Exhaustive: all 512 {c_in, a, b} values fed back-to-back by an incrementing stimulus, out_ready tied 1:
  - every result equals a + b + c_in.
  - zero mismatches flagged.
  - consecutive acceptances spaced exactly 6 cycles.
- Protocol: in_valid held high continuously with a changing every cycle → each result corresponds to the a/b value present on its acceptance edge only.
